multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Parametrised multi-cycle successor to the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one combinational step.
- Adds wait-state handshakes for memory and the IN port, branch resolution from the ALU zero flag, a resumable halt, and a retired-instruction counter.
- Sits between the instruction register/PC and the datapath; drives the same control nets as the existing decoder plus PC/IR write strobes.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 4, width of cu_aluOp.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPCODE_W  opcode field from memory data. Sampled into an internal opcode register on the FETCH->DECODE transition.
- zero  in  1  ALU zero flag, valid in EXEC.
- mem_ready  in  1  memory access complete (instruction or data).
- in_valid  in  1  input-port data valid.
- resume  in  1  leave HALT.
- cu_writeReg, cu_regDest, cu_memtoReg, cu_Jump, cu_inSignal, cu_aluScr, cu_writeEnable, cu_readEnable, cu_Branch, cu_hlt  out  1 each  datapath controls.
- cu_aluOp  out  ALUOP_W  ALU operation.
- cu_pcWrite  out  1  PC <= PC+1 strobe.
- cu_irWrite  out  1  IR load strobe.
- cu_outStrobe  out  1  OUT port write pulse.
- cu_illegal  out  1  illegal-opcode flag (feature-dependent).
- cu_state  out  3  current state code, for debug.
- cu_retired  out  CNT_W  retired-instruction count.

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, WAIT_IN=6, HALT=7.
- Outputs are decoded combinationally from the state register and the opcode register (opreg). Every control not listed as asserted is 0; no X is ever driven.
- Reset (async, rst_n=0):
  - state=IDLE, opreg=0, cu_retired=0, cu_illegal=0.
  - All outputs 0.
  - IDLE->FETCH on the first clk edge after rst_n rises.
- FETCH:
  - cu_readEnable=1.
  - Hold while mem_ready=0.
  - When mem_ready=1: cu_irWrite=1 and cu_pcWrite=1 in that cycle; opreg<=opcode; go to DECODE.
- DECODE:
  - JUMP (0x17): cu_Jump=1; ->FETCH; retire.
  - NOP (0x18): ->FETCH; retire.
  - HLT (0x19): ->HALT; retire.
  - IN (0x15): ->WAIT_IN.
  - All others: ->EXEC.
- EXEC:
  - ALU R-type (0x00-0x08): cu_regDest=0, cu_aluScr=0. cu_aluOp per code: 0001 add, 0010 sub, 0101 and, 0110 or, 0111 xor, 1011 slt, 1100 mul, 1101 div, 1110 rem. ->WB.
  - Immediate (0x0B-0x0E, 0x11-0x13): cu_aluScr=1. cu_aluOp per code: 0001 addi, 0010 subi, 0011 inc, 0100 dec, 1000 not, 1001 sll, 1010 srl. ->WB.
  - LW (0x0F), SW (0x10): cu_aluScr=1, cu_aluOp=0001 (address add). ->MEM.
  - LWI (0x14): ->WB.
  - BEQ (0x09): cu_aluOp=0010; cu_Branch=zero. ->FETCH; retire.
  - BNE (0x0A): cu_aluOp=0010; cu_Branch=!zero. ->FETCH; retire.
  - OUT (0x16): cu_outStrobe=1 for exactly one cycle. ->FETCH; retire.
- MEM:
  - LW: cu_readEnable=1; wait mem_ready; ->WB.
  - SW: cu_writeEnable=1; wait mem_ready; ->FETCH; retire.
- WAIT_IN:
  - cu_inSignal=1; hold until in_valid=1; ->WB.
- WB:
  - cu_writeReg=1.
  - cu_regDest=1 for R-type only.
  - cu_memtoReg=1 for LW only.
  - cu_inSignal=1 for IN.
  - cu_aluOp and cu_aluScr held from EXEC.
  - ->FETCH; retire.
- HALT:
  - cu_hlt=1.
  - resume=1 -> FETCH; otherwise stay.
- Retire: cu_retired increments by 1 on the transition that completes an instruction. It saturates at 2^CNT_W-1 (no wrap).
- Simultaneous events: mem_ready and in_valid are ignored outside the states that wait on them; resume is ignored outside HALT.
- Reset mid-instruction aborts immediately to IDLE with no retire and no write strobes.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an unlisted opcode in DECODE sets sticky cu_illegal=1 and goes to HALT without retiring. cu_illegal clears only on reset.
- Undefined: an unlisted opcode is treated as NOP (->FETCH, retired), and cu_illegal is tied 0.

Test Plan:
- Reset, then ADD (0x00) with mem_ready=1 -> states 1,2,3,5 then 1. WB has cu_writeReg=1, cu_regDest=1, cu_aluOp=0001. cu_retired=1.
- LW (0x0F), mem_ready low for 3 cycles in MEM -> MEM held 3 cycles with cu_readEnable=1; WB cu_memtoReg=1. Total 8 cycles FETCH->next FETCH.
- BEQ with zero=1, then BNE with zero=1 -> cu_Branch=1 in the first EXEC, 0 in the second. Each takes 3 cycles; retired +2.
- IN (0x15) with in_valid asserted after 5 cycles -> WAIT_IN held 5 cycles, then WB with cu_writeReg=1, cu_inSignal=1.
- HLT (0x19) -> cu_hlt=1 held. resume pulse -> FETCH next cycle. Assert rst_n=0 during a subsequent EXEC -> state=0 and all outputs 0 asynchronously.
- Opcode 0x3F: with ILLEGAL_TRAP_EN -> cu_illegal=1, state=7, retired unchanged. Without it -> state 2->1, retired +1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with memory/IN wait states and a resumable halt.
// Optional build macro ILLEGAL_TRAP_EN: unlisted opcodes trap to HALT and set a sticky cu_illegal flag.
module multicycle_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                in_valid,
  input  logic                resume,
  output logic                cu_writeReg,
  output logic                cu_regDest,
  output logic                cu_memtoReg,
  output logic                cu_Jump,
  output logic                cu_inSignal,
  output logic                cu_aluScr,
  output logic                cu_writeEnable,
  output logic                cu_readEnable,
  output logic                cu_Branch,
  output logic                cu_hlt,
  output logic [ALUOP_W-1:0]  cu_aluOp,
  output logic                cu_pcWrite,
  output logic                cu_irWrite,
  output logic                cu_outStrobe,
  output logic                cu_illegal,
  output logic [2:0]          cu_state,
  output logic [CNT_W-1:0]    cu_retired
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_WAIT_IN = 3'd6,
    S_HALT    = 3'd7
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(8'h00);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(8'h01);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(8'h02);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(8'h03);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(8'h04);
  localparam logic [OPCODE_W-1:0] OP_SLT  = OPCODE_W'(8'h05);
  localparam logic [OPCODE_W-1:0] OP_MUL  = OPCODE_W'(8'h06);
  localparam logic [OPCODE_W-1:0] OP_DIV  = OPCODE_W'(8'h07);
  localparam logic [OPCODE_W-1:0] OP_REM  = OPCODE_W'(8'h08);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(8'h09);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(8'h0A);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(8'h0B);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(8'h0C);
  localparam logic [OPCODE_W-1:0] OP_INC  = OPCODE_W'(8'h0D);
  localparam logic [OPCODE_W-1:0] OP_DEC  = OPCODE_W'(8'h0E);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(8'h0F);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(8'h10);
  localparam logic [OPCODE_W-1:0] OP_NOT  = OPCODE_W'(8'h11);
  localparam logic [OPCODE_W-1:0] OP_SLL  = OPCODE_W'(8'h12);
  localparam logic [OPCODE_W-1:0] OP_SRL  = OPCODE_W'(8'h13);
  localparam logic [OPCODE_W-1:0] OP_LWI  = OPCODE_W'(8'h14);
  localparam logic [OPCODE_W-1:0] OP_IN   = OPCODE_W'(8'h15);
  localparam logic [OPCODE_W-1:0] OP_OUT  = OPCODE_W'(8'h16);
  localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(8'h17);
  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(8'h18);
  localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(8'h19);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opreg_q, opreg_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                retire;
  logic                is_rtype, is_imm, is_mem;
  logic [ALUOP_W-1:0]  alu_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opreg_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      opreg_q   <= opreg_d;
      retired_q <= retired_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign cu_illegal = illegal_q;
`else
  assign cu_illegal = 1'b0;
`endif

  assign is_rtype = (opreg_q <= OP_REM);
  assign is_imm   = ((opreg_q >= OP_ADDI) && (opreg_q <= OP_DEC)) ||
                    ((opreg_q >= OP_NOT) && (opreg_q <= OP_SRL));
  assign is_mem   = (opreg_q == OP_LW) || (opreg_q == OP_SW);

  // ALU operation shared by EXEC and WB so WB holds what EXEC presented
  always_comb begin
    alu_code = '0;
    case (opreg_q)
      OP_ADD, OP_ADDI, OP_LW, OP_SW:   alu_code = ALUOP_W'(4'b0001);
      OP_SUB, OP_SUBI, OP_BEQ, OP_BNE: alu_code = ALUOP_W'(4'b0010);
      OP_INC:                          alu_code = ALUOP_W'(4'b0011);
      OP_DEC:                          alu_code = ALUOP_W'(4'b0100);
      OP_AND:                          alu_code = ALUOP_W'(4'b0101);
      OP_OR:                           alu_code = ALUOP_W'(4'b0110);
      OP_XOR:                          alu_code = ALUOP_W'(4'b0111);
      OP_NOT:                          alu_code = ALUOP_W'(4'b1000);
      OP_SLL:                          alu_code = ALUOP_W'(4'b1001);
      OP_SRL:                          alu_code = ALUOP_W'(4'b1010);
      OP_SLT:                          alu_code = ALUOP_W'(4'b1011);
      OP_MUL:                          alu_code = ALUOP_W'(4'b1100);
      OP_DIV:                          alu_code = ALUOP_W'(4'b1101);
      OP_REM:                          alu_code = ALUOP_W'(4'b1110);
      default:                         alu_code = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    opreg_d        = opreg_q;
    retire         = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d      = illegal_q;
`endif
    cu_writeReg    = 1'b0;
    cu_regDest     = 1'b0;
    cu_memtoReg    = 1'b0;
    cu_Jump        = 1'b0;
    cu_inSignal    = 1'b0;
    cu_aluScr      = 1'b0;
    cu_writeEnable = 1'b0;
    cu_readEnable  = 1'b0;
    cu_Branch      = 1'b0;
    cu_hlt         = 1'b0;
    cu_aluOp       = '0;
    cu_pcWrite     = 1'b0;
    cu_irWrite     = 1'b0;
    cu_outStrobe   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        cu_readEnable = 1'b1;
        if (mem_ready) begin
          cu_irWrite = 1'b1;
          cu_pcWrite = 1'b1;
          opreg_d    = opcode;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opreg_q == OP_JUMP) begin
          cu_Jump = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (opreg_q == OP_NOP) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (opreg_q == OP_HLT) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else if (opreg_q == OP_IN) begin
          state_d = S_WAIT_IN;
        end else if (opreg_q > OP_HLT) begin
`ifdef ILLEGAL_TRAP_EN
          illegal_d = 1'b1;
          state_d   = S_HALT;
`else
          retire  = 1'b1;
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cu_aluOp  = alu_code;
        cu_aluScr = is_imm || is_mem;
        if (is_rtype || is_imm || (opreg_q == OP_LWI)) begin
          state_d = S_WB;
        end else if (is_mem) begin
          state_d = S_MEM;
        end else begin
          // Branches and OUT complete here
          cu_Branch    = ((opreg_q == OP_BEQ) && zero) || ((opreg_q == OP_BNE) && !zero);
          cu_outStrobe = (opreg_q == OP_OUT);
          retire       = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_MEM: begin
        cu_readEnable  = (opreg_q == OP_LW);
        cu_writeEnable = (opreg_q != OP_LW);
        if (mem_ready) begin
          if (opreg_q == OP_LW) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WAIT_IN: begin
        cu_inSignal = 1'b1;
        if (in_valid) state_d = S_WB;
      end
      S_WB: begin
        cu_writeReg = 1'b1;
        cu_regDest  = is_rtype;
        cu_memtoReg = (opreg_q == OP_LW);
        cu_inSignal = (opreg_q == OP_IN);
        cu_aluOp    = alu_code;
        cu_aluScr   = is_imm || is_mem;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_HALT: begin
        cu_hlt = 1'b1;
        if (resume) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter saturates rather than wrapping
  assign retired_d = (retire && (retired_q != {CNT_W{1'b1}})) ? retired_q + CNT_W'(1) : retired_q;

  assign cu_state   = state_q;
  assign cu_retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: per-instruction expected cycle traces built from instruction-class rules.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        in_valid = 1'b0;
  logic        resume = 1'b0;
  logic        cu_writeReg, cu_regDest, cu_memtoReg, cu_Jump, cu_inSignal, cu_aluScr;
  logic        cu_writeEnable, cu_readEnable, cu_Branch, cu_hlt;
  logic [3:0]  cu_aluOp;
  logic        cu_pcWrite, cu_irWrite, cu_outStrobe, cu_illegal;
  logic [2:0]  cu_state;
  logic [15:0] cu_retired;

  multicycle_control_unit #(.OPCODE_W(6), .ALUOP_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .in_valid(in_valid), .resume(resume),
    .cu_writeReg(cu_writeReg), .cu_regDest(cu_regDest), .cu_memtoReg(cu_memtoReg),
    .cu_Jump(cu_Jump), .cu_inSignal(cu_inSignal), .cu_aluScr(cu_aluScr),
    .cu_writeEnable(cu_writeEnable), .cu_readEnable(cu_readEnable), .cu_Branch(cu_Branch),
    .cu_hlt(cu_hlt), .cu_aluOp(cu_aluOp), .cu_pcWrite(cu_pcWrite), .cu_irWrite(cu_irWrite),
    .cu_outStrobe(cu_outStrobe), .cu_illegal(cu_illegal), .cu_state(cu_state),
    .cu_retired(cu_retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr, regdst, mtr, jmp, ins, src, we, re, br, hlt;
    logic [3:0] aop;
    logic       pcw, irw, outs, ill;
    logic [2:0] st;
  } ctl_t;

  typedef struct {
    ctl_t exp;
    logic mr, iv, z, res;
    int   op;
  } step_t;

  step_t trace[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_retired = 0;
  logic  ill_model = 1'b0;

  function automatic ctl_t observed();
    ctl_t a;
    a = {cu_writeReg, cu_regDest, cu_memtoReg, cu_Jump, cu_inSignal, cu_aluScr,
         cu_writeEnable, cu_readEnable, cu_Branch, cu_hlt, cu_aluOp,
         cu_pcWrite, cu_irWrite, cu_outStrobe, cu_illegal, cu_state};
    return a;
  endfunction

  // ALU operation table by opcode, as listed in the instruction set
  function automatic logic [3:0] alu_of(input int op);
    case (op)
      0: return 4'd1;   1: return 4'd2;   2: return 4'd5;   3: return 4'd6;
      4: return 4'd7;   5: return 4'd11;  6: return 4'd12;  7: return 4'd13;
      8: return 4'd14;  9: return 4'd2;   10: return 4'd2;  11: return 4'd1;
      12: return 4'd2;  13: return 4'd3;  14: return 4'd4;  15: return 4'd1;
      16: return 4'd1;  17: return 4'd8;  18: return 4'd9;  19: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  // A cycle with only the state expected and all non-waited inputs randomized
  function automatic step_t blank(input int st);
    step_t s;
    s.exp     = '0;
    s.exp.st  = 3'(st);
    s.exp.ill = ill_model;
    s.mr      = 1'($urandom);
    s.iv      = 1'($urandom);
    s.z       = 1'($urandom);
    s.res     = 1'($urandom);
    s.op      = int'($urandom_range(0, 63));
    return s;
  endfunction

  function automatic void do_retire();
    if (exp_retired < 65535) exp_retired++;
  endfunction

  // Build the expected cycle-by-cycle trace of one instruction
  task automatic gen(input int op, input int fw, input int mw, input int iw,
                     input logic z, input int hc);
    step_t s;
    bit rt, imm, lw, sw, to_wb, halt;
    rt = (op <= 8);
    imm = (op >= 11 && op <= 14) || (op >= 17 && op <= 19);
    lw = (op == 15);
    sw = (op == 16);
    to_wb = 0;
    halt = 0;
    for (int i = 0; i < fw; i++) begin
      s = blank(1); s.exp.re = 1; s.mr = 0; trace.push_back(s);
    end
    s = blank(1); s.exp.re = 1; s.exp.irw = 1; s.exp.pcw = 1; s.mr = 1; s.op = op;
    trace.push_back(s);
    s = blank(2); s.exp.jmp = (op == 23); trace.push_back(s);
    if (op == 23 || op == 24) begin
      do_retire();
    end else if (op == 25) begin
      do_retire(); halt = 1;
    end else if (op == 21) begin
      for (int i = 0; i < iw; i++) begin
        s = blank(6); s.exp.ins = 1; s.iv = 0; trace.push_back(s);
      end
      s = blank(6); s.exp.ins = 1; s.iv = 1; trace.push_back(s);
      to_wb = 1;
    end else if (op > 25) begin
`ifdef ILLEGAL_TRAP_EN
      ill_model = 1'b1; halt = 1;
`else
      do_retire();
`endif
    end else begin
      s = blank(3);
      s.z = z;
      s.exp.aop = alu_of(op);
      s.exp.src = imm || lw || sw;
      s.exp.br = (op == 9) ? z : (op == 10) ? !z : 1'b0;
      s.exp.outs = (op == 22);
      trace.push_back(s);
      if (rt || imm || op == 20) begin
        to_wb = 1;
      end else if (lw || sw) begin
        for (int i = 0; i <= mw; i++) begin
          s = blank(4); s.exp.re = lw; s.exp.we = sw; s.mr = (i == mw); trace.push_back(s);
        end
        if (lw) to_wb = 1;
        else do_retire();
      end else begin
        do_retire();
      end
    end
    if (to_wb) begin
      s = blank(5);
      s.exp.wr = 1; s.exp.regdst = rt; s.exp.mtr = lw; s.exp.ins = (op == 21);
      s.exp.src = imm || lw; s.exp.aop = (rt || imm || lw) ? alu_of(op) : 4'd0;
      trace.push_back(s);
      do_retire();
    end
    if (halt) begin
      for (int i = 0; i <= hc; i++) begin
        s = blank(7); s.exp.hlt = 1; s.res = (i == hc); trace.push_back(s);
      end
    end
  endtask

  // Replay the queued trace, one comparison per cycle, then check the counter
  task automatic run_trace(input string tag);
    step_t s;
    ctl_t  a;
    int    n = 0;
    while (trace.size() > 0) begin
      s = trace.pop_front();
      @(negedge clk);
      mem_ready = s.mr; in_valid = s.iv; zero = s.z; resume = s.res; opcode = 6'(s.op);
      #1;
      a = observed();
      checks++;
      if (a !== s.exp) begin
        errors++;
        $display("[TB] FAIL %s step %0d: controls got 0x%h required 0x%h", tag, n, a, s.exp);
      end
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (cu_retired !== 16'(exp_retired)) begin
      errors++;
      $display("[TB] FAIL %s retired: got %0d required %0d", tag, cu_retired, exp_retired);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (observed() !== ctl_t'(0) || cu_retired !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got 0x%h/%0d required 0/0", observed(), cu_retired);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (observed() !== ctl_t'(0)) begin
      errors++;
      $display("[TB] FAIL reset_idle: got 0x%h required 0", observed());
    end
  endtask

  task automatic test_add();
    gen(0, 0, 0, 0, 1'b0, 0); run_trace("add");
  endtask

  task automatic test_lw_wait();
    gen(15, 0, 3, 0, 1'b0, 0); run_trace("lw_wait");
  endtask

  task automatic test_branch();
    gen(9, 0, 0, 0, 1'b1, 0);  run_trace("beq_z1");
    gen(10, 0, 0, 0, 1'b1, 0); run_trace("bne_z1");
    gen(10, 1, 0, 0, 1'b0, 0); run_trace("bne_z0");
  endtask

  task automatic test_in_wait();
    gen(21, 0, 0, 5, 1'b0, 0); run_trace("in_wait");
  endtask

  task automatic test_halt();
    gen(25, 0, 0, 0, 1'b0, 3); run_trace("hlt_resume");
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      gen(int'($urandom_range(0, 25)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          int'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 2)));
      run_trace($sformatf("rand%0d", k));
    end
  endtask

  task automatic test_illegal();
    gen(63, 0, 0, 0, 1'b0, 1); run_trace("illegal_3f");
    gen(24, 0, 0, 0, 1'b0, 0); run_trace("nop_after_illegal");
  endtask

  task automatic test_reset_mid();
    int saved;
    saved = exp_retired;
    gen(1, 0, 0, 0, 1'b0, 0);
    while (trace.size() > 2) void'(trace.pop_back());
    exp_retired = saved;
    run_trace("sub_pre_reset");
    @(negedge clk);
    #1;
    checks++;
    if (cu_state !== 3'd3 || cu_aluOp !== 4'd2) begin
      errors++;
      $display("[TB] FAIL mid_exec: got state %0d aluOp %0d required 3/2", cu_state, cu_aluOp);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== ctl_t'(0) || cu_retired !== 16'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: got 0x%h/%0d required 0/0", observed(), cu_retired);
    end
    exp_retired = 0;
    ill_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    gen(22, 0, 0, 0, 1'b0, 0); run_trace("out_after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_in_wait();
    test_halt();
    test_random();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
